// File: rtl/config_pkg.sv
// Shared configuration-bus constants and the loader state type; also used by the tiles.
package config_pkg;

  localparam int ADDR_W = 6;
  // 80 switch bits followed by the 3 + 3 + 2 compute-block bits
  localparam int DATA_W = 80 + 3 + 3 + 2;
  localparam int SYNC_W = 8;
  localparam logic [SYNC_W-1:0] SYNC_WORD = 8'hA5;
  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_COUNT,
    ST_ADDR,
    ST_DATA,
    ST_PAR,
    ST_WRITE,
    ST_DONE,
    ST_ERROR
  } state_e;

endpackage

// File: rtl/config_loader_bit_deserializer.sv
// Generic MSB-first shift register with a field bit counter; value_next is the value
// being registered this cycle, last_bit flags the final bit of a len-bit field.
module bit_deserializer #(
  parameter int W  = 8,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          shift_en,
  input  logic          bit_in,
  input  logic [CW-1:0] len,
  output logic [W-1:0]  value_next,
  output logic          last_bit
);

  logic [W-1:0]  value_q, value_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter wraps to zero on the final bit, so the next field starts counting fresh.
  always_comb begin
    value_d  = value_q;
    cnt_d    = cnt_q;
    last_bit = 1'b0;
    if (clear) begin
      value_d = '0;
      cnt_d   = '0;
    end else if (shift_en) begin
      value_d  = {value_q[W-2:0], bit_in};
      last_bit = (cnt_q == len - CW'(1));
      cnt_d    = last_bit ? '0 : cnt_q + CW'(1);
    end
  end

  assign value_next = value_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value_q <= '0;
      cnt_q   <= '0;
    end else begin
      value_q <= value_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/config_loader.sv
// Bitstream loader: hunts for the sync word, then issues one config_en write per frame.
// Define CONFIG_LOADER_PARITY_EN to add a per-frame even-parity bit and the ERROR path.
module config_loader
  import config_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bs_valid,
  input  logic              bs_data,
  output logic              bs_ready,
  output logic              config_en,
  output logic [ADDR_W-1:0] config_addr,
  output logic [0:DATA_W-1] config_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] frames_written
);

  state_e              state_q, state_d;
  logic [SYNC_W-1:0]   window_q, window_d, window_shift;
  logic [ADDR_W-1:0]   n_q, n_d, addr_q, addr_d, frames_q, frames_d;
  logic [ADDR_W-1:0]   config_addr_q, config_addr_d;
  logic [0:DATA_W-1]   config_data_q, config_data_d;
  logic                config_en_q, config_en_d;
  logic                busy_q, busy_d, done_q, done_d, bs_ready_q, bs_ready_d;
  logic                accept, issue_write;
  logic                des_clear, des_shift, des_last;
  logic [CNT_W-1:0]    des_len;
  logic [DATA_W-1:0]   des_next;

  assign accept       = bs_valid && bs_ready_q;
  assign window_shift = {window_q[SYNC_W-2:0], bs_data};
  assign des_clear    = (state_q == ST_HUNT) && accept && (window_shift == SYNC_WORD);
  assign des_shift    = accept && (state_q inside {ST_COUNT, ST_ADDR, ST_DATA});
  assign des_len      = (state_q == ST_DATA) ? CNT_W'(DATA_W) : CNT_W'(ADDR_W);

  bit_deserializer #(
    .W  (DATA_W),
    .CW (CNT_W)
  ) u_deser (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (des_clear),
    .shift_en   (des_shift),
    .bit_in     (bs_data),
    .len        (des_len),
    .value_next (des_next),
    .last_bit   (des_last)
  );

`ifdef CONFIG_LOADER_PARITY_EN
  logic error_q, error_d, par_ok;
  // In PAR the deserializer is idle, so des_next still holds the frame's data bits.
  assign par_ok = ((^addr_q) ^ (^des_next) ^ bs_data) == 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    window_d      = window_q;
    n_d           = n_q;
    addr_d        = addr_q;
    frames_d      = frames_q;
    config_en_d   = 1'b0;
    config_addr_d = config_addr_q;
    config_data_d = config_data_q;
    busy_d        = busy_q;
    done_d        = done_q;
    issue_write   = 1'b0;
`ifdef CONFIG_LOADER_PARITY_EN
    error_d       = error_q;
`endif
    case (state_q)
      ST_HUNT: begin
        if (accept) window_d = window_shift;
        if (des_clear) begin
          state_d = ST_COUNT;
          busy_d  = 1'b1;
        end
      end
      ST_COUNT: begin
        if (des_last) begin
          n_d = des_next[ADDR_W-1:0];
          if (des_next[ADDR_W-1:0] == '0) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = ST_ADDR;
          end
        end
      end
      ST_ADDR: begin
        if (des_last) begin
          addr_d  = des_next[ADDR_W-1:0];
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
`ifdef CONFIG_LOADER_PARITY_EN
        if (des_last) state_d = ST_PAR;
`else
        if (des_last) issue_write = 1'b1;
`endif
      end
`ifdef CONFIG_LOADER_PARITY_EN
      ST_PAR: begin
        if (accept) begin
          if (par_ok) begin
            issue_write = 1'b1;
          end else begin
            state_d = ST_ERROR;
            busy_d  = 1'b0;
            error_d = 1'b1;
          end
        end
      end
`endif
      ST_WRITE: begin
        if (frames_q == n_q) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = ST_ADDR;
        end
      end
      default: ;
    endcase

    if (issue_write) begin
      state_d       = ST_WRITE;
      config_en_d   = 1'b1;
      config_addr_d = addr_q;
      config_data_d = des_next;
      frames_d      = frames_q + ADDR_W'(1);
    end

    bs_ready_d = state_d inside {ST_HUNT, ST_COUNT, ST_ADDR, ST_DATA, ST_PAR};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_HUNT;
      window_q      <= '0;
      n_q           <= '0;
      addr_q        <= '0;
      frames_q      <= '0;
      config_en_q   <= 1'b0;
      config_addr_q <= '0;
      config_data_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      bs_ready_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      window_q      <= window_d;
      n_q           <= n_d;
      addr_q        <= addr_d;
      frames_q      <= frames_d;
      config_en_q   <= config_en_d;
      config_addr_q <= config_addr_d;
      config_data_q <= config_data_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      bs_ready_q    <= bs_ready_d;
    end
  end

`ifdef CONFIG_LOADER_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst_n) error_q <= 1'b0;
    else        error_q <= error_d;
  end
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  assign bs_ready       = bs_ready_q;
  assign config_en      = config_en_q;
  assign config_addr    = config_addr_q;
  assign config_data    = config_data_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign frames_written = frames_q;

endmodule

// File: tb/tb_config_loader.sv
// Scoreboard bench for config_loader: expected writes are queued as frames are driven
// and popped by a monitor on every config_en pulse.
`timescale 1ns/1ps
module tb_config_loader;
  import config_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              bs_valid = 1'b0;
  logic              bs_data = 1'b0;
  logic              bs_ready, config_en, busy, done, error;
  logic [ADDR_W-1:0] config_addr, frames_written;
  logic [0:DATA_W-1] config_data;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [0:DATA_W-1] data;
  } frame_t;

  frame_t exp_q[$];
  int     checks = 0;
  int     passed = 0;
  int     pulses = 0;
  bit     stall_en = 1'b0;

  config_loader dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bs_valid       (bs_valid),
    .bs_data        (bs_data),
    .bs_ready       (bs_ready),
    .config_en      (config_en),
    .config_addr    (config_addr),
    .config_data    (config_data),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .frames_written (frames_written)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
  endtask

  // Every write strobe must match the oldest queued frame.
  always @(negedge clk) begin
    frame_t e;
    if (config_en === 1'b1) begin
      pulses++;
      checkOutput("ready_in_write", bs_ready, 1'b0);
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_write", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("write_addr", config_addr, e.addr);
        checkOutput("write_data", config_data, e.data);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the bit has transferred.
  task automatic applyStimulus(input logic b);
    int guard;
    if (stall_en) begin
      while ($urandom_range(0, 1) == 1) begin
        bs_valid = 1'b0;
        @(negedge clk);
      end
    end
    bs_valid = 1'b1;
    bs_data  = b;
    guard    = 0;
    while (bs_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) checkOutput("ready_timeout", 1'b0, 1'b1);
    @(negedge clk);
    bs_valid = 1'b0;
  endtask

  task automatic applyBits(input logic [127:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) applyStimulus(v[i]);
  endtask

  task automatic applyFrame(input logic [ADDR_W-1:0] a, input logic [0:DATA_W-1] d,
                            input int n_data, input bit bad_parity);
    frame_t f;
    logic   par;
    f.addr = a;
    f.data = d;
    par    = (^a) ^ (^d);
    applyBits(a, ADDR_W);
`ifdef CONFIG_LOADER_PARITY_EN
    for (int i = 0; i < n_data; i++) applyStimulus(d[i]);
    if (n_data == DATA_W) begin
      if (!bad_parity) exp_q.push_back(f);
      applyStimulus(par ^ bad_parity);
    end
`else
    for (int i = 0; i < n_data; i++) begin
      if (i == DATA_W - 1 && !bad_parity && par !== 1'bx) exp_q.push_back(f);
      applyStimulus(d[i]);
    end
`endif
  endtask

  task automatic checkResetState();
    checkOutput("rst_bs_ready", bs_ready, 1'b0);
    checkOutput("rst_config_en", config_en, 1'b0);
    checkOutput("rst_config_addr", config_addr, '0);
    checkOutput("rst_config_data", config_data, '0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_error", error, 1'b0);
    checkOutput("rst_frames", frames_written, '0);
  endtask

  task automatic applyReset(input bit check);
    @(negedge clk);
    rst_n    = 1'b0;
    bs_valid = 1'b0;
    @(negedge clk);
    if (check) checkResetState();
    exp_q.delete();
    rst_n = 1'b1;
    @(negedge clk);
    if (check) checkOutput("ready_after_reset", bs_ready, 1'b1);
  endtask

  function automatic logic [0:DATA_W-1] randData();
    logic [0:DATA_W-1] d;
    for (int i = 0; i < DATA_W; i++) d[i] = 1'($urandom_range(0, 1));
    return d;
  endfunction

  initial begin
    logic [0:DATA_W-1] d;
    int p0;

    // Reset values, then N=0 load after a junk prefix
    repeat (2) @(negedge clk);
    checkResetState();
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("ready_after_reset", bs_ready, 1'b1);
    applyBits(3'b110, 3);
    applyBits(SYNC_WORD, SYNC_W);
    checkOutput("busy_after_sync", busy, 1'b1);
    applyBits(6'd0, ADDR_W);
    checkOutput("n0_done", done, 1'b1);
    checkOutput("n0_busy", busy, 1'b0);
    checkOutput("n0_ready", bs_ready, 1'b0);
    bs_valid = 1'b1;
    repeat (4) @(negedge clk);
    bs_valid = 1'b0;
    checkOutput("n0_pulses", pulses, 0);
    checkOutput("n0_frames", frames_written, '0);
    checkOutput("n0_done_sticky", done, 1'b1);

    // Single frame, data bits 0 and 87 set
    applyReset(1'b0);
    p0   = pulses;
    d    = '0;
    d[0] = 1'b1;
    d[DATA_W-1] = 1'b1;
    applyBits(SYNC_WORD, SYNC_W);
    applyBits(6'd1, ADDR_W);
    applyFrame(6'd5, d, DATA_W, 1'b0);
    @(negedge clk);
    checkOutput("f1_pulses", pulses - p0, 1);
    checkOutput("f1_addr_held", config_addr, 6'd5);
    checkOutput("f1_data0", config_data[0], 1'b1);
    checkOutput("f1_data87", config_data[DATA_W-1], 1'b1);
    checkOutput("f1_data_held", config_data, d);
    checkOutput("f1_frames", frames_written, 6'd1);
    checkOutput("f1_done", done, 1'b1);
    checkOutput("f1_en_low", config_en, 1'b0);

    // Three frames with random bs_valid stalls, duplicate address
    applyReset(1'b0);
    p0       = pulses;
    stall_en = 1'b1;
    applyBits(SYNC_WORD, SYNC_W);
    applyBits(6'd3, ADDR_W);
    applyFrame(6'd1, randData(), DATA_W, 1'b0);
    applyFrame(6'd2, randData(), DATA_W, 1'b0);
    applyFrame(6'd1, randData(), DATA_W, 1'b0);
    stall_en = 1'b0;
    @(negedge clk);
    checkOutput("f3_pulses", pulses - p0, 3);
    checkOutput("f3_frames", frames_written, 6'd3);
    checkOutput("f3_done", done, 1'b1);
    checkOutput("f3_queue_empty", exp_q.size(), 0);

    // Reset in the middle of frame 2 of 2, then a fresh load
    applyReset(1'b0);
    p0 = pulses;
    applyBits(SYNC_WORD, SYNC_W);
    applyBits(6'd2, ADDR_W);
    applyFrame(6'd7, randData(), DATA_W, 1'b0);
    applyFrame(6'd9, randData(), 40, 1'b0);
    applyReset(1'b1);
    checkOutput("abort_pulses", pulses - p0, 1);
    applyBits(SYNC_WORD, SYNC_W);
    applyBits(6'd1, ADDR_W);
    applyFrame(6'd3, randData(), DATA_W, 1'b0);
    @(negedge clk);
    checkOutput("abort_reload_pulses", pulses - p0, 2);
    checkOutput("abort_reload_done", done, 1'b1);

    // Sync embedded after an overlapping 1010 prefix
    applyReset(1'b0);
    p0 = pulses;
    applyBits(12'b1010_1010_0101 >> 1, 11);
    checkOutput("overlap_busy_early", busy, 1'b0);
    applyStimulus(1'b1);
    checkOutput("overlap_busy", busy, 1'b1);
    applyBits(6'd1, ADDR_W);
    applyFrame(6'h2A, randData(), DATA_W, 1'b0);
    @(negedge clk);
    checkOutput("overlap_pulses", pulses - p0, 1);
    checkOutput("overlap_done", done, 1'b1);

`ifdef CONFIG_LOADER_PARITY_EN
    // Good frame then a frame with flipped parity
    applyReset(1'b0);
    p0 = pulses;
    applyBits(SYNC_WORD, SYNC_W);
    applyBits(6'd2, ADDR_W);
    applyFrame(6'd4, randData(), DATA_W, 1'b0);
    applyFrame(6'd8, randData(), DATA_W, 1'b1);
    @(negedge clk);
    checkOutput("par_pulses", pulses - p0, 1);
    checkOutput("par_error", error, 1'b1);
    checkOutput("par_ready", bs_ready, 1'b0);
    checkOutput("par_done", done, 1'b0);
    checkOutput("par_busy", busy, 1'b0);
    checkOutput("par_frames", frames_written, 6'd1);
`else
    checkOutput("error_tied_low", error, 1'b0);
`endif

    checkOutput("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/config_loader.md
Name: config_loader

Overview:
- Drives the fabric configuration bus (config_en / config_addr / config_data) that the tiles and compute blocks decode.
- Deserialises a 1-bit bitstream that arrives through a valid/ready handshake.
- The bitstream format is: sync word, then frame count, then frames of {address, data}.
- Each frame produces exactly one single-cycle config_en write. The loader sits at the top level between the external programming pin and all tiles.

Parameters:
- ADDR_W, 6, config_addr width; the tile address space.
- DATA_W, 88, config_data width: 80 switch bits + 3 + 3 + 2 compute-block bits.
- SYNC_W, 8, sync word length.
- SYNC_WORD, 8'hA5, sync pattern marking the start of a bitstream.

Ports:
- clk  in  1  fabric clock.
- rst_n  in  1  reset; synchronous, active-low.
- bs_valid  in  1  bitstream bit valid.
- bs_data  in  1  bitstream bit.
- bs_ready  out  1  loader can accept a bit; a bit transfers when bs_valid && bs_ready at posedge clk.
- config_en  out  1  one-cycle write strobe to the configuration bus.
- config_addr  out  ADDR_W  target tile address; valid while config_en is high.
- config_data  out  [0:DATA_W-1]  configuration word; valid while config_en is high.
- busy  out  1  a load is in progress.
- done  out  1  all frames were written; sticky.
- error  out  1  bitstream fault; sticky; only driven when the parity feature is compiled in, otherwise tied 0.
- frames_written  out  ADDR_W  count of config_en pulses issued in this load.

Behaviour:
- Reset (rst_n=0 at posedge): applies regardless of state and abandons any partial frame, so no config_en is issued for it.
  - State goes to HUNT.
  - config_en=0, config_addr=0, config_data=0, busy=0, done=0, error=0, frames_written=0, bs_ready=0.
  - bs_ready rises to 1 on the cycle after rst_n returns high.
- States: HUNT, COUNT, ADDR, DATA, PAR (feature only), WRITE, DONE, ERROR.
- HUNT:
  - bs_ready=1.
  - Each accepted bit shifts into an SYNC_W-bit window, MSB first (window = {window[SYNC_W-2:0], bs_data}).
  - The window clears to 0 on entry.
  - When the updated window equals SYNC_WORD, go to COUNT and set busy=1.
- COUNT:
  - Accept ADDR_W bits MSB first as N, the number of frames.
  - If N=0, go directly to DONE.
  - Otherwise, go to ADDR.
- ADDR: accept ADDR_W bits MSB first into the address shift register.
- DATA:
  - Accept DATA_W bits. The first bit received lands at config_data[0] and the last at config_data[DATA_W-1].
  - After the last bit, go to WRITE (or PAR if the feature is enabled).
- WRITE:
  - Lasts exactly one cycle with bs_ready=0 and config_en=1.
  - config_addr and config_data are registered copies of the shift registers.
  - Latency: if the last data bit is accepted in cycle t, config_en is high in cycle t+1.
  - frames_written increments.
  - If frames_written+1 == N, go to DONE; otherwise go to ADDR.
- Outside WRITE:
  - config_en=0.
  - config_addr and config_data hold their last written values.
- DONE:
  - busy=0, done=1, bs_ready=0.
  - Stays until reset; further bits are not accepted.
- ERROR:
  - busy=0, error=1, bs_ready=0.
  - Stays until reset.
- Bit counters:
  - Clear on every state entry.
  - A state transition happens on the posedge that accepts the final bit of a field.
- bs_valid low: stalls with no state change; counters are held.
- Duplicate addresses across frames are written again; the last write wins at the tile.

Optional Feature:
- CONFIG_LOADER_PARITY_EN defined:
  - After DATA, the PAR state accepts 1 bit.
  - Required: XOR of all ADDR_W+DATA_W frame bits XOR the parity bit == 0 (even parity).
  - On match, go to WRITE.
  - On mismatch, go to ERROR with no config_en for that frame; earlier frames remain written.
- Undefined: no PAR state, no parity bit in the stream, error is tied 0.

Decomposition:
- Shared package config_pkg:
  - ADDR_W and DATA_W, with DATA_W derived as 80+3+3+2 so it is shared with the tile.
  - SYNC_W and SYNC_WORD.
  - The state enum type.
- One natural sub-module: bit_deserializer. It is a generic width-parameterised shift register with a bit counter, a load-clear input and a last_bit output, and it is reused for the COUNT, ADDR and DATA fields.

Test Plan:
- Reset, then 3 arbitrary bits followed by 10100101 and N=0 -> done=1 on the cycle after the last N bit, no config_en ever, busy returns 0.
- Sync + N=1 + addr 6'd5 + data with only bit index 0 and bit 87 set -> one config_en pulse, config_addr=5, config_data[0]=1, config_data[87]=1, other bits 0, frames_written=1, done=1.
- Sync + N=3, addresses 1,2,1, with bs_valid deasserted randomly 50% of cycles -> exactly 3 config_en pulses, addresses in order 1,2,1, and no bit accepted while bs_ready=0.
- rst_n pulsed low after 40 data bits of frame 2 of N=2 -> only 1 config_en pulse, all outputs at reset values, then a new sync is accepted.
- Sync word 10100101 embedded after the prefix 1010 (overlapping hunt) -> sync is still detected at the correct bit.
- CONFIG_LOADER_PARITY_EN defined: N=2, frame 1 with correct parity and frame 2 with wrong parity -> one config_en, error=1, bs_ready=0, done=0.
